// File: rtl/ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_bridge
// Description : AHB-Lite slave to APB2 master bridge, single HCLK domain.
//               Define AHB_APB_ALIGN_CHECK_EN to enable the misaligned-address
//               ERROR response.
// Revision    : 1.0
// ============================================================================
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY_IN,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic                  HREADY_OUT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WDATA  = 3'd1;
    localparam logic [2:0] c_ST_SETUP  = 3'd2;
    localparam logic [2:0] c_ST_ACCESS = 3'd3;
    localparam logic [2:0] c_ST_ERR1   = 3'd4;
    localparam logic [2:0] c_ST_ERR2   = 3'd5;

    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic                  w_req;
    logic                  w_can_accept;
    logic                  w_misaligned;
    logic                  w_accept;

    assign w_req = HSEL && ((HTRANS == c_HTRANS_NONSEQ) || (HTRANS == c_HTRANS_SEQ))
                   && HREADY_IN && HREADY_OUT;

    // New address phases are taken only where a transfer may start.
    assign w_can_accept = (r_state == c_ST_IDLE) || (r_state == c_ST_ACCESS);

`ifdef AHB_APB_ALIGN_CHECK_EN
    assign w_misaligned = |HADDR[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_accept = w_req && w_can_accept && !w_misaligned;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE, c_ST_ACCESS: begin
                if (w_req && w_can_accept) begin
                    if (w_misaligned) begin
                        w_next_state = c_ST_ERR1;
                    end else if (HWRITE) begin
                        w_next_state = c_ST_WDATA;
                    end else begin
                        w_next_state = c_ST_SETUP;
                    end
                end
            end
            c_ST_WDATA: w_next_state = c_ST_SETUP;
            c_ST_SETUP: w_next_state = c_ST_ACCESS;
            c_ST_ERR1:  w_next_state = c_ST_ERR2;
            c_ST_ERR2:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        HREADY_OUT = 1'b1;
        HRESP      = 1'b0;
        case (r_state)
            c_ST_WDATA: HREADY_OUT = 1'b0;
            c_ST_SETUP: begin
                PSEL       = 1'b1;
                HREADY_OUT = 1'b0;
            end
            c_ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
`ifdef AHB_APB_ALIGN_CHECK_EN
            c_ST_ERR1: begin
                HRESP      = 1'b1;
                HREADY_OUT = 1'b0;
            end
            c_ST_ERR2: HRESP = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            if (r_state == c_ST_WDATA) begin
                PWDATA <= HWDATA;
            end
            if ((r_state == c_ST_ACCESS) && !PWRITE) begin
                r_hrdata <= PRDATA;
            end
        end
    end

    // Read data bypasses the capture register in ACCESS so HREADY_OUT and data align.
    assign HRDATA = ((r_state == c_ST_ACCESS) && !PWRITE) ? PRDATA : r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_apb_bridge
// Description : Randomised bench for ahb_apb_bridge with a memory-level model.
// Revision    : 1.0
// ============================================================================
module tb_ahb_apb_bridge;

    localparam int c_MAXOPS = 64;
    localparam int c_LOG    = 1024;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    wire         HREADY_IN;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        HREADY_OUT;
    logic [31:0] PRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY_IN(HREADY_IN),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADY_OUT(HREADY_OUT), .PRDATA(PRDATA), .PSEL(PSEL),
        .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY_IN = HREADY_OUT;

    // APB slave: simple word memory
    logic [31:0] mem [0:255] = '{default: 32'h0};
    always @(posedge HCLK) begin
        if (PSEL && PENABLE && PWRITE) mem[PADDR[9:2]] <= PWDATA;
    end
    assign PRDATA = PSEL ? mem[PADDR[9:2]] : 32'hDEAD_0000;

    // APB monitor: logs every ACCESS cycle and counts SETUP/ACCESS ordering errors
    logic [31:0] apb_a [0:c_LOG-1];
    logic [31:0] apb_d [0:c_LOG-1];
    logic        apb_w [0:c_LOG-1];
    int          apb_wp = 0;
    int          proto_err = 0;
    logic        prev_setup = 1'b0;
    logic        mon_en = 1'b1;
    always @(negedge HCLK) begin
        if (mon_en && ((PENABLE && !PSEL) || ((PSEL && PENABLE) != prev_setup)))
            proto_err <= proto_err + 1;
        if (PSEL && PENABLE) begin
            apb_a[apb_wp % c_LOG] <= PADDR;
            apb_d[apb_wp % c_LOG] <= PWDATA;
            apb_w[apb_wp % c_LOG] <= PWRITE;
            apb_wp <= apb_wp + 1;
        end
        prev_setup <= PSEL && !PENABLE;
    end

    int total = 0;
    int bad = 0;
    int rp = 0;

    // Transfer list for the AHB master
    int          n_ops;
    logic        op_wr   [c_MAXOPS];
    logic        op_seq  [c_MAXOPS];
    logic [31:0] op_addr [c_MAXOPS];
    logic [31:0] op_wd   [c_MAXOPS];
    logic [31:0] op_rd   [c_MAXOPS];
    int          op_gap  [c_MAXOPS];
    int          op_waits[c_MAXOPS];
    logic        op_resp [c_MAXOPS];
    logic        op_werr [c_MAXOPS];

    // Reference model: memory contents and last read/write values
    logic [31:0] ref_mem [0:255] = '{default: 32'h0};
    logic [31:0] exp_pwdata = '0;
    logic [31:0] exp_hrdata = '0;

    task automatic add_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int gap);
        op_wr[n_ops] = wr;   op_addr[n_ops] = addr; op_wd[n_ops] = wd;
        op_gap[n_ops] = gap; op_seq[n_ops] = 1'b0;  op_rd[n_ops] = 'x;
        op_waits[n_ops] = 0; op_resp[n_ops] = 1'b0; op_werr[n_ops] = 1'b0;
        n_ops++;
    endtask

    task automatic ref_step(input int i, output logic [31:0] e_rd, output int e_waits);
        int idx;
        idx = int'(op_addr[i][9:2]);
        if (op_wr[i]) begin
            ref_mem[idx] = op_wd[i];
            exp_pwdata   = op_wd[i];
            e_rd         = exp_hrdata;
            e_waits      = 2;
        end else begin
            e_rd       = ref_mem[idx];
            exp_hrdata = e_rd;
            e_waits    = 1;
        end
    endtask

    // Pipelined AHB master; entered and left #1 after a rising edge.
    task automatic run_ops();
        int a = 0, d = -1, gap, cyc = 0;
        logic issue, rdy, resp;
        logic [31:0] rd;
        gap = (n_ops > 0) ? op_gap[0] : 0;
        while ((a < n_ops || d >= 0) && cyc < 2000) begin
            issue  = (a < n_ops) && (gap == 0);
            HSEL   = issue;
            HTRANS = issue ? (op_seq[a] ? 2'b11 : 2'b10) : 2'b00;
            if (issue) begin
                HADDR  = op_addr[a];
                HWRITE = op_wr[a];
            end
            if (d >= 0) HWDATA = op_wd[d];
            @(negedge HCLK);
            rdy = HREADY_OUT; resp = HRESP; rd = HRDATA;
            @(posedge HCLK); #1;
            cyc++;
            if (rdy) begin
                if (d >= 0) begin
                    op_rd[d]   = rd;
                    op_resp[d] = resp;
                end
                if (issue) begin
                    d = a;
                    a++;
                    gap = (a < n_ops) ? op_gap[a] : 0;
                end else begin
                    d = -1;
                    if (gap > 0) gap--;
                end
            end else if (d >= 0) begin
                op_waits[d]++;
                op_werr[d] = op_werr[d] | resp;
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        total++;
        if (cyc >= 2000) begin
            bad++;
            $display("FAIL run_ops_timeout: cycles=%0d limit=2000", cyc);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        total++;
        if ({PSEL, PENABLE, PWRITE, HRESP, HREADY_OUT} !== 5'b00001 ||
            PADDR !== 32'h0 || PWDATA !== 32'h0 || HRDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset: psel/pen/pwr/hresp/hrdy=%b paddr=%h pwdata=%h hrdata=%h want 00001/0/0/0",
                     {PSEL, PENABLE, PWRITE, HRESP, HREADY_OUT}, PADDR, PWDATA, HRDATA);
        end
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] e_rd; int e_w;
        n_ops = 0;
        add_op(1'b1, 32'h0, 32'hBEEFBEEF, 0);
        add_op(1'b0, 32'h0, 32'h0, 0);
        run_ops();
        for (int i = 0; i < n_ops; i++) begin
            ref_step(i, e_rd, e_w);
            total++;
            if ((!op_wr[i] && op_rd[i] !== e_rd) || op_waits[i] != e_w || op_resp[i] !== 1'b0) begin
                bad++;
                $display("FAIL wr_rd_xfer%0d: rd=%h waits=%0d resp=%b want rd=%h waits=%0d resp=0",
                         i, op_rd[i], op_waits[i], op_resp[i], e_rd, e_w);
            end
            total++;
            if (rp >= apb_wp || apb_a[rp % c_LOG] !== op_addr[i] || apb_w[rp % c_LOG] !== op_wr[i] ||
                (op_wr[i] && apb_d[rp % c_LOG] !== op_wd[i])) begin
                bad++;
                $display("FAIL wr_rd_apb%0d: paddr=%h pwrite=%b pwdata=%h want %h/%b/%h",
                         i, apb_a[rp % c_LOG], apb_w[rp % c_LOG], apb_d[rp % c_LOG], op_addr[i], op_wr[i], op_wd[i]);
            end
            rp++;
        end
        total++;
        if (op_rd[1] !== 32'hBEEFBEEF) begin
            bad++;
            $display("FAIL wr_rd_value: got=%h want=beefbeef", op_rd[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_rd; int e_w;
        n_ops = 0;
        add_op(1'b1, 32'h4, 32'hDEADBEEF, 0);
        add_op(1'b1, 32'h8, 32'hBEEFCAFE, 0);
        add_op(1'b0, 32'h4, 32'h0, 0);
        add_op(1'b0, 32'h8, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            add_op(1'b1, 32'h20 + 32'(4 * i), 32'h10000000 + 32'(i), 0);
            op_seq[n_ops - 1] = (i != 0);
        end
        for (int i = 0; i < 4; i++) begin
            add_op(1'b0, 32'h20 + 32'(4 * i), 32'h0, 0);
            op_seq[n_ops - 1] = (i != 0);
        end
        run_ops();
        for (int i = 0; i < n_ops; i++) begin
            ref_step(i, e_rd, e_w);
            total++;
            if ((!op_wr[i] && op_rd[i] !== e_rd) || op_waits[i] != e_w || op_resp[i] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_xfer%0d: rd=%h waits=%0d resp=%b want rd=%h waits=%0d resp=0",
                         i, op_rd[i], op_waits[i], op_resp[i], e_rd, e_w);
            end
            total++;
            if (rp >= apb_wp || apb_a[rp % c_LOG] !== op_addr[i] || apb_w[rp % c_LOG] !== op_wr[i] ||
                (op_wr[i] && apb_d[rp % c_LOG] !== op_wd[i])) begin
                bad++;
                $display("FAIL b2b_apb%0d: paddr=%h pwrite=%b pwdata=%h want %h/%b/%h",
                         i, apb_a[rp % c_LOG], apb_w[rp % c_LOG], apb_d[rp % c_LOG], op_addr[i], op_wr[i], op_wd[i]);
            end
            rp++;
        end
        total++;
        if (op_rd[2] !== 32'hDEADBEEF || op_rd[3] !== 32'hBEEFCAFE || op_rd[11] !== 32'h10000003) begin
            bad++;
            $display("FAIL b2b_values: got=%h %h %h want=deadbeef beefcafe 10000003",
                     op_rd[2], op_rd[3], op_rd[11]);
        end
    endtask

    task automatic test_ignored();
        int seen;
        seen = apb_wp;
        for (int k = 0; k < 12; k++) begin
            HSEL   = (k >= 4 && k < 8);
            HTRANS = (k < 4) ? 2'b00 : ((k < 8) ? 2'b01 : 2'b10);
            HWRITE = 1'b1; HADDR = 32'h40; HWDATA = 32'hFFFF0000 + 32'(k);
            @(negedge HCLK);
            total++;
            if (PSEL !== 1'b0 || HREADY_OUT !== 1'b1) begin
                bad++;
                $display("FAIL ignored_cyc%0d: psel=%b hready=%b want psel=0 hready=1", k, PSEL, HREADY_OUT);
            end
            @(posedge HCLK); #1;
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (3) @(posedge HCLK);
        #1;
        total++;
        if (PWDATA !== exp_pwdata || apb_wp != seen) begin
            bad++;
            $display("FAIL ignored_end: pwdata=%h apb_xfers=%0d want pwdata=%h apb_xfers=%0d",
                     PWDATA, apb_wp, exp_pwdata, seen);
        end
    endtask

    task automatic test_idle_gap();
        logic [31:0] e_rd; int e_w;
        for (int pass = 0; pass < 2; pass++) begin
            n_ops = 0;
            add_op(pass == 0, 32'h50, 32'hCAFEBEEF, 0);
            run_ops();
            ref_step(0, e_rd, e_w);
            total++;
            if ((pass == 1 && op_rd[0] !== 32'hCAFEBEEF) || op_waits[0] != e_w ||
                rp >= apb_wp || apb_a[rp % c_LOG] !== 32'h50) begin
                bad++;
                $display("FAIL gap_xfer%0d: rd=%h waits=%0d paddr=%h want rd=cafebeef waits=%0d paddr=50",
                         pass, op_rd[0], op_waits[0], apb_a[rp % c_LOG], e_w);
            end
            rp++;
            if (pass == 0) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge HCLK);
                    total++;
                    if (PSEL !== 1'b0 || HREADY_OUT !== 1'b1 || HRDATA !== exp_hrdata) begin
                        bad++;
                        $display("FAIL gap_idle%0d: psel=%b hready=%b hrdata=%h want 0/1/%h",
                                 k, PSEL, HREADY_OUT, HRDATA, exp_hrdata);
                    end
                    @(posedge HCLK); #1;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e_rd; int e_w;
        n_ops = 0;
        for (int i = 0; i < 48; i++) begin
            add_op(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            op_seq[i] = 1'($urandom_range(0, 1));
        end
        run_ops();
        for (int i = 0; i < n_ops; i++) begin
            ref_step(i, e_rd, e_w);
            total++;
            if ((!op_wr[i] && op_rd[i] !== e_rd) || op_waits[i] != e_w || op_resp[i] !== 1'b0) begin
                bad++;
                $display("FAIL rand_xfer%0d: rd=%h waits=%0d resp=%b want rd=%h waits=%0d resp=0",
                         i, op_rd[i], op_waits[i], op_resp[i], e_rd, e_w);
            end
            total++;
            if (rp >= apb_wp || apb_a[rp % c_LOG] !== op_addr[i] || apb_w[rp % c_LOG] !== op_wr[i] ||
                (op_wr[i] && apb_d[rp % c_LOG] !== op_wd[i])) begin
                bad++;
                $display("FAIL rand_apb%0d: paddr=%h pwrite=%b pwdata=%h want %h/%b/%h",
                         i, apb_a[rp % c_LOG], apb_w[rp % c_LOG], apb_d[rp % c_LOG], op_addr[i], op_wr[i], op_wd[i]);
            end
            rp++;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = apb_wp;
        mon_en = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h60;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678;
        @(posedge HCLK); #1;
        total++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b100) begin
            bad++;
            $display("FAIL mid_setup: psel/pen/hrdy=%b want 100", {PSEL, PENABLE, HREADY_OUT});
        end
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        total++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b001 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: psel/pen/hrdy=%b paddr=%h pwdata=%h want 001/0/0",
                     {PSEL, PENABLE, HREADY_OUT}, PADDR, PWDATA);
        end
        exp_pwdata = '0;
        exp_hrdata = '0;
        repeat (4) @(posedge HCLK);
        #1;
        total++;
        if (apb_wp != seen || mem[24] !== ref_mem[24] || PSEL !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: apb_xfers=%0d mem=%h psel=%b want %0d/%h/0", apb_wp, mem[24], PSEL,
                     seen, ref_mem[24]);
        end
        mon_en = 1'b1;
    endtask

`ifdef AHB_APB_ALIGN_CHECK_EN
    task automatic test_align_error();
        int seen;
        for (int pass = 0; pass < 2; pass++) begin
            seen  = apb_wp;
            n_ops = 0;
            add_op(pass == 0, (pass == 0) ? 32'h2 : 32'h101, 32'h11111111, 0);
            run_ops();
            total++;
            if (op_resp[0] !== 1'b1 || op_werr[0] !== 1'b1 || op_waits[0] != 1) begin
                bad++;
                $display("FAIL align_resp%0d: resp_last=%b resp_first=%b waits=%0d want 1/1/1",
                         pass, op_resp[0], op_werr[0], op_waits[0]);
            end
            total++;
            if (apb_wp != seen || PWDATA !== exp_pwdata) begin
                bad++;
                $display("FAIL align_noapb%0d: apb_xfers=%0d pwdata=%h want %0d/%h",
                         pass, apb_wp, PWDATA, seen, exp_pwdata);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_ignored();
        test_idle_gap();
        test_random();
        test_reset_mid();
`ifdef AHB_APB_ALIGN_CHECK_EN
        test_align_error();
`endif
        test_write_read();
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("FAIL apb_protocol: violations=%0d want 0", proto_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
